uart_receiver: RTL and testbench
================================

// Module: uart_receiver
// PURPOSE
//   Deserialises the team UART frame from serial_in into bytes for the host-side command path.
//   Pairs with uart_transmitter and uses the same SYMBOL_EDGE_TIME.
//   Frame format: idle high; start bit 0; 8 data bits MSB first; 1 pad bit (value ignored); stop bit 1.
//   Drives rts to throttle the remote transmitter while a received byte is still unconsumed.
// PARAMETERS
//   SYMBOL_EDGE_TIME  16  clocks per bit symbol (>=4, even values preferred)
// PORTS
//   clock           in   1  system clock
//   reset           in   1  synchronous, active-high
//   serial_in       in   1  async serial line, idle high
//   data_out        out  8  received byte, stable while data_out_valid=1
//   data_out_valid  out  1  byte available
//   data_out_ready  in   1  consumer accepts byte when valid&ready
//   rts             out  1  1 = may send; 0 while holding buffer full
//   frame_err       out  1  1-cycle pulse: stop bit sampled 0
//   overrun         out  1  1-cycle pulse: byte completed while buffer full (new byte dropped)
// BEHAVIOUR
//   Reset values: data_out=0, data_out_valid=0, rts=1, frame_err=0, overrun=0; FSM goes to IDLE; counters cleared.
//   Reset mid-frame: discards the partial frame; the FSM re-arms only after the synchronised line is seen high.
//   Input: 2-FF synchroniser; rx_s is the synchronised line. Edge detect on rx_s 1->0 while in IDLE.
//   Tick counter: counts 0..SYMBOL_EDGE_TIME-1; it is reloaded to 0 on start-edge detect, not free-running.
//   Sampling: first sample at SYMBOL_EDGE_TIME/2-1 ticks after the edge, then every SYMBOL_EDGE_TIME (mid-bit).
//   FSM:
//     IDLE : on falling edge of rx_s -> START, with tick=0.
//     START: at mid-bit: if rx_s==0 -> DATA, bit_cnt=7; else (glitch) -> IDLE.
//     DATA : each sample does shift_reg <= {shift_reg[6:0], rx_s}. At bit_cnt==0 -> PAD; else bit_cnt-1.
//     PAD  : one symbol; sample ignored -> STOP.
//     STOP : at mid-bit:
//              rx_s==1 and buffer empty: load data_out, set data_out_valid.
//              rx_s==1 and buffer full: pulse overrun, drop byte, keep old data_out.
//              rx_s==0: pulse frame_err, drop byte.
//            In all cases -> IDLE.
//   Latency: data_out_valid rises the cycle after the stop-bit sample clock.
//   Handshake: valid held until the valid&ready cycle, then deasserts next cycle.
//     Accept and new load on the same cycle: the new byte loads and valid stays 1 (no overrun).
//   rts = ~data_out_valid (registered).
//   A stop bit followed immediately by a start edge is handled: IDLE detects the edge on the next rx_s transition.
//   frame_err and overrun are never asserted on the same cycle.
// CONFIGURATION
//   RX_MAJORITY_VOTE_EN defined: each bit value is the 2-of-3 majority of rx_s at
//     mid-1, mid, mid+1 ticks. Decision timing is unchanged (made at mid+1, applied as at mid).
//     START aborts only if the majority reads 1.
//   RX_MAJORITY_VOTE_EN undefined: single sample of rx_s at mid-bit.
// STRUCTURE
//   uart_pkg: FSM state localparams (IDLE/START/DATA/PAD/STOP), UART_DATA_BITS=8, UART_PAD_BITS=1.
//     uart_transmitter's state encoding moves into uart_pkg as well.
//   Sub-module uart_rx_sampler: synchroniser, tick counter, mid-bit strobe, and optional majority vote.
//     Outputs: bit_strobe, bit_value, start_edge.
//   uart_receiver: FSM, shift register, holding buffer, rts and status pulses.
// TESTING (SYMBOL_EDGE_TIME=16; also a loopback with uart_transmitter)
//   Send 0xA5, ready=1 -> data_out=0xA5, valid high 1 cycle, rts low 1 cycle, no errors.
//   Send 0x3C then 0xC3 back-to-back, ready=0 until after the second stop bit
//     -> data_out=0x3C retained, overrun pulses once, rts=0 throughout.
//   Send 0x55 with stop bit forced 0 -> frame_err pulses, valid stays 0, next 0x0F received correctly.
//   Low glitch of 3 clocks on an idle line -> FSM returns to IDLE, no valid, no errors.
//   Assert reset during bit 4 of 0xFF, then send 0x81 -> only 0x81 is delivered.
//   RX_MAJORITY_VOTE_EN: 1-clock inverted glitch at the mid-bit of each data bit of 0x96 -> 0x96 received.
//     Without the macro, the same stimulus -> 0x69.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART frame constants and FSM state encodings for receiver and transmitter.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;
    localparam int UART_PAD_BITS  = 1;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PAD,
        RX_STOP
    } rx_state_e;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PAD,
        TX_STOP
    } tx_state_e;

endpackage

// File: rtl/uart_rx_sampler.sv
// rtl/uart_rx_sampler.sv - line synchroniser, start-edge detect, tick counter and mid-bit strobe.
// RX_MAJORITY_VOTE_EN selects a 2-of-3 vote around mid-bit instead of a single sample.
module uart_rx_sampler #(
    parameter int SYMBOL_EDGE_TIME = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic serial_in,
    input  logic rx_idle_i,
    output logic bit_strobe,
    output logic bit_value,
    output logic start_edge
);

    localparam int TW = $clog2(SYMBOL_EDGE_TIME);
    localparam logic [TW-1:0] TICK_LAST = TW'(SYMBOL_EDGE_TIME - 1);
    localparam logic [TW-1:0] TICK_MID  = TW'(SYMBOL_EDGE_TIME / 2 - 1);

    logic          rx_meta_q;
    logic          rx_s_q;
    logic          rx_prev_q;
    logic [TW-1:0] tick_q;

    // Prev resets low so a line held low through reset cannot fake a start edge.
    assign start_edge = rx_idle_i & rx_prev_q & ~rx_s_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            rx_meta_q <= 1'b0;
            rx_s_q    <= 1'b0;
            rx_prev_q <= 1'b0;
            tick_q    <= '0;
        end else begin
            rx_meta_q <= serial_in;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
            if (rx_idle_i || start_edge || tick_q == TICK_LAST) begin
                tick_q <= '0;
            end else begin
                tick_q <= tick_q + 1'b1;
            end
        end
    end

`ifdef RX_MAJORITY_VOTE_EN
    localparam logic [TW-1:0] TICK_VOTE = TW'(SYMBOL_EDGE_TIME / 2);

    logic [1:0] hist_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            hist_q <= '0;
        end else begin
            hist_q <= {hist_q[0], rx_s_q};
        end
    end

    // Decided once the mid+1 sample is present; hist holds mid-1 and mid.
    assign bit_strobe = ~rx_idle_i & (tick_q == TICK_VOTE);
    assign bit_value  = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s_q) | (hist_q[0] & rx_s_q);
`else
    assign bit_strobe = ~rx_idle_i & (tick_q == TICK_MID);
    assign bit_value  = rx_s_q;
`endif

endmodule

// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - UART frame FSM, shift register, one-byte holding buffer, rts and status pulses.
// Optional RX_MAJORITY_VOTE_EN is handled inside uart_rx_sampler.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int SYMBOL_EDGE_TIME = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       serial_in,
    output logic [7:0] data_out,
    output logic       data_out_valid,
    input  logic       data_out_ready,
    output logic       rts,
    output logic       frame_err,
    output logic       overrun
);

    rx_state_e  state_q;
    logic [2:0] bit_cnt_q;
    logic [7:0] shift_q;
    logic [7:0] data_q;
    logic       valid_q;
    logic       rts_q;
    logic       frame_err_q;
    logic       overrun_q;

    logic bit_strobe;
    logic bit_value;
    logic start_edge;

    logic accept;
    logic stop_hit;
    logic load_d;
    logic valid_d;

    uart_rx_sampler #(
        .SYMBOL_EDGE_TIME(SYMBOL_EDGE_TIME)
    ) u_sampler (
        .clock      (clock),
        .reset      (reset),
        .serial_in  (serial_in),
        .rx_idle_i  (state_q == RX_IDLE),
        .bit_strobe (bit_strobe),
        .bit_value  (bit_value),
        .start_edge (start_edge)
    );

    // A byte accepted in the same cycle frees the buffer for the incoming one.
    always_comb begin
        accept   = valid_q & data_out_ready;
        stop_hit = (state_q == RX_STOP) & bit_strobe;
        load_d   = stop_hit & bit_value & (~valid_q | accept);
        valid_d  = load_d | (valid_q & ~accept);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= RX_IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            rts_q       <= 1'b1;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            if (load_d) begin
                data_q <= shift_q;
            end
            valid_q     <= valid_d;
            rts_q       <= ~valid_d;
            frame_err_q <= stop_hit & ~bit_value;
            overrun_q   <= stop_hit & bit_value & valid_q & ~accept;

            case (state_q)
                RX_IDLE: begin
                    if (start_edge) begin
                        state_q <= RX_START;
                    end
                end
                RX_START: begin
                    if (bit_strobe) begin
                        if (!bit_value) begin
                            state_q   <= RX_DATA;
                            bit_cnt_q <= 3'(UART_DATA_BITS - 1);
                        end else begin
                            state_q <= RX_IDLE;
                        end
                    end
                end
                RX_DATA: begin
                    if (bit_strobe) begin
                        shift_q <= {shift_q[6:0], bit_value};
                        if (bit_cnt_q == '0) begin
                            state_q   <= RX_PAD;
                            bit_cnt_q <= 3'(UART_PAD_BITS - 1);
                        end else begin
                            bit_cnt_q <= bit_cnt_q - 1'b1;
                        end
                    end
                end
                RX_PAD: begin
                    if (bit_strobe) begin
                        if (bit_cnt_q == '0) begin
                            state_q <= RX_STOP;
                        end else begin
                            bit_cnt_q <= bit_cnt_q - 1'b1;
                        end
                    end
                end
                RX_STOP: begin
                    if (bit_strobe) begin
                        state_q <= RX_IDLE;
                    end
                end
                default: state_q <= RX_IDLE;
            endcase
        end
    end

    assign data_out       = data_q;
    assign data_out_valid = valid_q;
    assign rts            = rts_q;
    assign frame_err      = frame_err_q;
    assign overrun        = overrun_q;

endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - randomized frame stimulus for uart_receiver checked against a frame-level model.
module tb_uart_receiver;

    localparam int SET = 16;

    logic       clock = 1'b0;
    logic       reset;
    logic       serial_in;
    logic [7:0] data_out;
    logic       data_out_valid;
    logic       data_out_ready;
    logic       rts;
    logic       frame_err;
    logic       overrun;

    int checks   = 0;
    int failures = 0;

    int valid_cyc   = 0;
    int rts_low_cyc = 0;
    int fe_cnt      = 0;
    int ov_cnt      = 0;
    int both_cnt    = 0;
    int rts_bad     = 0;
    int rx_n        = 0;
    logic [7:0] rx_log [256];

    uart_receiver #(.SYMBOL_EDGE_TIME(SET)) dut (
        .clock          (clock),
        .reset          (reset),
        .serial_in      (serial_in),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .data_out_ready (data_out_ready),
        .rts            (rts),
        .frame_err      (frame_err),
        .overrun        (overrun)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (!reset) begin
            if (data_out_valid) valid_cyc++;
            if (!rts) rts_low_cyc++;
            if (frame_err) fe_cnt++;
            if (overrun) ov_cnt++;
            if (frame_err && overrun) both_cnt++;
            if (rts !== ~data_out_valid) rts_bad++;
            if (data_out_valid && data_out_ready) begin
                rx_log[rx_n[7:0]] = data_out;
                rx_n++;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Glitch inverts the line for the single clock that lands on the bit centre.
    task automatic drive_bit(input logic v, input logic glitch);
        if (glitch) begin
            serial_in = v;
            tick(SET / 2);
            serial_in = ~v;
            tick(1);
            serial_in = v;
            tick(SET / 2 - 1);
        end else begin
            serial_in = v;
            tick(SET);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_v, input logic glitch);
        logic [7:0] bb;
        bb = b;
        drive_bit(1'b0, 1'b0);
        for (int i = 7; i >= 0; i--) drive_bit(bb[i], glitch);
        drive_bit(1'($urandom_range(0, 1)), 1'b0);
        drive_bit(stop_v, 1'b0);
        serial_in = 1'b1;
    endtask

    // Value the receiver should report for a byte sent with centre glitches.
    function automatic logic [7:0] glitched_expect(input logic [7:0] b);
`ifdef RX_MAJORITY_VOTE_EN
        return b;
`else
        return ~b;
`endif
    endfunction

    initial begin
        int b_rx, b_v, b_r, b_fe, b_ov;
        logic [7:0] exp_q [$];
        logic [7:0] r;

        reset          = 1'b1;
        serial_in      = 1'b1;
        data_out_ready = 1'b0;
        tick(3);
        check_eq("reset_data", 32'(data_out), 32'h0);
        check_eq("reset_valid", 32'(data_out_valid), 32'h0);
        check_eq("reset_rts", 32'(rts), 32'h1);
        check_eq("reset_ferr", 32'(frame_err), 32'h0);
        check_eq("reset_ovr", 32'(overrun), 32'h0);
        reset = 1'b0;
        tick(2 * SET);

        // Single byte, consumer always ready.
        b_rx = rx_n; b_v = valid_cyc; b_r = rts_low_cyc; b_fe = fe_cnt; b_ov = ov_cnt;
        data_out_ready = 1'b1;
        send_frame(8'hA5, 1'b1, 1'b0);
        tick(SET);
        check_eq("a5_count", 32'(rx_n - b_rx), 32'd1);
        check_eq("a5_data", 32'(rx_log[b_rx[7:0]]), 32'hA5);
        check_eq("a5_valid_cycles", 32'(valid_cyc - b_v), 32'd1);
        check_eq("a5_rts_low_cycles", 32'(rts_low_cyc - b_r), 32'd1);
        check_eq("a5_ferr", 32'(fe_cnt - b_fe), 32'd0);
        check_eq("a5_ovr", 32'(ov_cnt - b_ov), 32'd0);

        // Random bytes with random idle gaps, including zero-gap back-to-back frames.
        b_rx = rx_n;
        exp_q.delete();
        for (int k = 0; k < 8; k++) begin
            r = 8'($urandom);
            exp_q.push_back(r);
            send_frame(r, 1'b1, 1'b0);
            tick($urandom_range(0, 40));
        end
        tick(SET);
        check_eq("rand_count", 32'(rx_n - b_rx), 32'd8);
        for (int k = 0; k < 8; k++) begin
            check_eq($sformatf("rand_data%0d", k), 32'(rx_log[8'(b_rx + k)]), 32'(exp_q[k]));
        end

        // Overrun: second byte completes while the first is still held.
        b_rx = rx_n; b_v = valid_cyc; b_r = rts_low_cyc; b_fe = fe_cnt; b_ov = ov_cnt;
        data_out_ready = 1'b0;
        send_frame(8'h3C, 1'b1, 1'b0);
        send_frame(8'hC3, 1'b1, 1'b0);
        tick(2 * SET);
        check_eq("ovr_data_kept", 32'(data_out), 32'h3C);
        check_eq("ovr_valid_held", 32'(data_out_valid), 32'h1);
        check_eq("ovr_rts_low", 32'(rts), 32'h0);
        check_eq("ovr_pulses", 32'(ov_cnt - b_ov), 32'd1);
        check_eq("ovr_ferr", 32'(fe_cnt - b_fe), 32'd0);
        check_eq("ovr_rts_tracks_valid", 32'(rts_low_cyc - b_r), 32'(valid_cyc - b_v));
        data_out_ready = 1'b1;
        tick(1);
        data_out_ready = 1'b0;
        tick(2);
        check_eq("ovr_drain_count", 32'(rx_n - b_rx), 32'd1);
        check_eq("ovr_drain_data", 32'(rx_log[b_rx[7:0]]), 32'h3C);
        check_eq("ovr_valid_cleared", 32'(data_out_valid), 32'h0);
        check_eq("ovr_rts_back", 32'(rts), 32'h1);

        // Framing error then a clean byte.
        b_rx = rx_n; b_v = valid_cyc; b_fe = fe_cnt; b_ov = ov_cnt;
        data_out_ready = 1'b1;
        send_frame(8'h55, 1'b0, 1'b0);
        tick(2 * SET);
        check_eq("ferr_pulses", 32'(fe_cnt - b_fe), 32'd1);
        check_eq("ferr_no_valid", 32'(valid_cyc - b_v), 32'd0);
        send_frame(8'h0F, 1'b1, 1'b0);
        tick(SET);
        check_eq("ferr_next_count", 32'(rx_n - b_rx), 32'd1);
        check_eq("ferr_next_data", 32'(rx_log[b_rx[7:0]]), 32'h0F);
        check_eq("ferr_next_ovr", 32'(ov_cnt - b_ov), 32'd0);

        // Short low glitch on an idle line is rejected at the start-bit centre.
        b_rx = rx_n; b_v = valid_cyc; b_fe = fe_cnt; b_ov = ov_cnt;
        serial_in = 1'b0;
        tick(3);
        serial_in = 1'b1;
        tick(3 * SET);
        check_eq("glitch_no_valid", 32'(valid_cyc - b_v), 32'd0);
        check_eq("glitch_ferr", 32'(fe_cnt - b_fe), 32'd0);
        check_eq("glitch_ovr", 32'(ov_cnt - b_ov), 32'd0);
        r = 8'($urandom);
        send_frame(r, 1'b1, 1'b0);
        tick(SET);
        check_eq("glitch_then_byte", 32'(rx_log[b_rx[7:0]]), 32'(r));

        // Reset in the middle of 0xFF, then 0x81.
        b_rx = rx_n; b_fe = fe_cnt; b_ov = ov_cnt;
        drive_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1, 1'b0);
        serial_in = 1'b1;
        tick(SET / 2);
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        check_eq("midreset_valid", 32'(data_out_valid), 32'h0);
        check_eq("midreset_rts", 32'(rts), 32'h1);
        tick(SET / 2 + 5 * SET);
        send_frame(8'h81, 1'b1, 1'b0);
        tick(SET);
        check_eq("midreset_count", 32'(rx_n - b_rx), 32'd1);
        check_eq("midreset_data", 32'(rx_log[b_rx[7:0]]), 32'h81);
        check_eq("midreset_errs", 32'((fe_cnt - b_fe) + (ov_cnt - b_ov)), 32'd0);

        // Single-clock glitch at every data-bit centre.
        b_rx = rx_n;
        send_frame(8'h96, 1'b1, 1'b1);
        tick(SET);
        r = 8'($urandom);
        send_frame(r, 1'b1, 1'b1);
        tick(SET);
        check_eq("vote_count", 32'(rx_n - b_rx), 32'd2);
        check_eq("vote_96", 32'(rx_log[b_rx[7:0]]), 32'(glitched_expect(8'h96)));
        check_eq("vote_rand", 32'(rx_log[8'(b_rx + 1)]), 32'(glitched_expect(r)));

        check_eq("never_ferr_and_ovr", 32'(both_cnt), 32'd0);
        check_eq("rts_is_not_valid", 32'(rts_bad), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
